processor: RTL and testbench

//  - Single-issue 8-bit core: one instruction per clock from vector_in, 16-entry register file.
//  - Shared-memory reads go through a request/grant bus arbiter; one core of the dual-core system.
//  - Instruction = {opcode[CONTROL_WIDTH], fld_a[ADDR_WIDTH], fld_b[ADDR_WIDTH]} (12 bits by default).

---
 rtl/processor_pkg.sv | 36 +++
 rtl/processor_alu.sv | 47 ++++
 rtl/processor.sv | 176 +++++++++++++++++
 tb/tb_processor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// processor_pkg
// Shared definitions for the single-issue 8-bit core: opcode encodings,
// FSM state encoding and the run/halt status constants.
// Ports: none (package).
// Optional feature: PROCESSOR_MUL_EN enables the MUL opcode in processor_alu.

package processor_pkg;

    // Opcode encodings (top field of the instruction word)
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_LOAD = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_MOV  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Values driven on status_out
    localparam logic STATUS_START = 1'b1;
    localparam logic STATUS_HALT  = 1'b0;

    // Core FSM states
    typedef enum logic [1:0] {
        EXEC   = 2'd0,
        WAIT   = 2'd1,
        READ   = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/processor_alu.sv
// processor_alu
// Purely combinational ALU for the core. Produces the result of a
// register-to-register opcode and flags whether that opcode writes back.
// Ports:
//   op_i       opcode field
//   a_i, b_i   register operands R[a], R[b]
//   result_o   D-bit result (wraps, no carry out)
//   writeEn_o  1 when op_i is a single-cycle op that writes R[a]
// Optional feature: define PROCESSOR_MUL_EN to add MUL (1011); otherwise
// 1011 is treated like any undefined opcode.

module processor_alu
    import processor_pkg::*;
#(
    parameter int CONTROL_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic [CONTROL_WIDTH-1:0] op_i,
    input  logic [DATA_WIDTH-1:0]    a_i,
    input  logic [DATA_WIDTH-1:0]    b_i,
    output logic [DATA_WIDTH-1:0]    result_o,
    output logic                     writeEn_o
);

    // Decode the opcode; anything not listed (NOP, LOAD, HALT, undefined)
    // leaves writeEn_o low so the register file is untouched.
    always_comb begin
        result_o  = '0;
        writeEn_o = 1'b0;
        case (op_i)
            CONTROL_WIDTH'(OP_ADD): begin result_o = a_i + b_i; writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_SUB): begin result_o = a_i - b_i; writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_AND): begin result_o = a_i & b_i; writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_OR):  begin result_o = a_i | b_i; writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_XOR): begin result_o = a_i ^ b_i; writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_NOT): begin result_o = ~b_i;      writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_SHL): begin result_o = a_i << 1;  writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_SHR): begin result_o = a_i >> 1;  writeEn_o = 1'b1; end
            CONTROL_WIDTH'(OP_MOV): begin result_o = b_i;       writeEn_o = 1'b1; end
`ifdef PROCESSOR_MUL_EN
            CONTROL_WIDTH'(OP_MUL): begin result_o = a_i * b_i; writeEn_o = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/processor.sv
// processor
// Single-issue 8-bit core: executes one instruction per clock from vector_in
// against a 2**ADDR_WIDTH entry register file. LOAD reads shared memory via a
// request/grant bus arbiter handshake.
// Ports:
//   clk              rising-edge clock
//   reset_in         asynchronous active-high reset
//   vector_in        instruction {op, fld_a, fld_b}
//   data_in          shared-memory read data, valid while granted
//   bus_grant_in     arbiter grant
//   alu_out          registered result of last executed instruction
//   addr_out         registered memory address of current bus read
//   bus_request_out  registered bus request
//   status_out       1 = running, 0 = halted
// Optional feature: PROCESSOR_MUL_EN enables MUL (see processor_alu).

module processor
    import processor_pkg::*;
#(
    parameter int CONTROL_WIDTH = 4,
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                clk,
    input  logic                                reset_in,
    input  logic [CONTROL_WIDTH+2*ADDR_WIDTH-1:0] vector_in,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                bus_grant_in,
    output logic [DATA_WIDTH-1:0]               alu_out,
    output logic [ADDR_WIDTH-1:0]               addr_out,
    output logic                                bus_request_out,
    output logic                                status_out
);

    localparam int IW   = CONTROL_WIDTH + 2*ADDR_WIDTH;
    localparam int NREG = 2**ADDR_WIDTH;

    localparam logic [CONTROL_WIDTH-1:0] OpNop  = CONTROL_WIDTH'(OP_NOP);
    localparam logic [CONTROL_WIDTH-1:0] OpLoad = CONTROL_WIDTH'(OP_LOAD);
    localparam logic [CONTROL_WIDTH-1:0] OpHalt = CONTROL_WIDTH'(OP_HALT);

    logic [CONTROL_WIDTH-1:0] op;
    logic [ADDR_WIDTH-1:0]    fldA;
    logic [ADDR_WIDTH-1:0]    fldB;

    logic [DATA_WIDTH-1:0] regFile_q [NREG];
    logic [DATA_WIDTH-1:0] rA;
    logic [DATA_WIDTH-1:0] rB;

    logic [DATA_WIDTH-1:0] aluResult;
    logic                  aluWe;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] aluOut_q, aluOut_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] loadDest_q, loadDest_d;
    logic                  busReq_q, busReq_d;
    logic                  status_q, status_d;

    logic                  regWe;
    logic [ADDR_WIDTH-1:0] regWaddr;
    logic [DATA_WIDTH-1:0] regWdata;
    logic                  wakeOp;

    assign op   = vector_in[IW-1 -: CONTROL_WIDTH];
    assign fldA = vector_in[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign fldB = vector_in[ADDR_WIDTH-1:0];

    // Register reads are asynchronous, so a same-edge write is seen next cycle.
    assign rA = regFile_q[fldA];
    assign rB = regFile_q[fldB];

    // Anything other than NOP/HALT brings a halted core back to life.
    assign wakeOp = (op != OpNop) && (op != OpHalt);

    processor_alu #(
        .CONTROL_WIDTH (CONTROL_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_alu (
        .op_i      (op),
        .a_i       (rA),
        .b_i       (rB),
        .result_o  (aluResult),
        .writeEn_o (aluWe)
    );

    // FSM state register; reset returns to EXEC, which also aborts a LOAD.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= EXEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A waking HALTED core behaves exactly like EXEC,
    // including a LOAD that heads straight into WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC: begin
                if (op == OpLoad)      state_d = WAIT;
                else if (op == OpHalt) state_d = HALTED;
            end
            WAIT: begin
                if (bus_grant_in) state_d = READ;
            end
            READ: begin
                state_d = bus_grant_in ? EXEC : WAIT;
            end
            HALTED: begin
                if (op == OpLoad) state_d = WAIT;
                else if (wakeOp)  state_d = EXEC;
            end
            default: state_d = EXEC;
        endcase
    end

    // Output/datapath logic: decides what the registered outputs and the
    // register file take on at the coming edge. The LOAD target index is
    // latched at issue because vector_in is ignored while the read is pending.
    always_comb begin
        aluOut_d   = aluOut_q;
        addr_d     = addr_q;
        loadDest_d = loadDest_q;
        busReq_d   = busReq_q;
        status_d   = status_q;
        regWe      = 1'b0;
        regWaddr   = fldA;
        regWdata   = aluResult;
        if ((state_q == EXEC) || ((state_q == HALTED) && wakeOp)) begin
            if (state_q == HALTED) status_d = STATUS_START;
            if (aluWe) begin
                regWe    = 1'b1;
                aluOut_d = aluResult;
            end
            if (op == OpLoad) begin
                addr_d     = fldA;
                loadDest_d = fldB;
                busReq_d   = 1'b1;
            end
            if (op == OpHalt) status_d = STATUS_HALT;
        end else if ((state_q == READ) && bus_grant_in) begin
            regWe    = 1'b1;
            regWaddr = loadDest_q;
            regWdata = data_in;
            aluOut_d = data_in;
            busReq_d = 1'b0;
        end
    end

    // Output registers and register file.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            aluOut_q   <= '0;
            addr_q     <= '0;
            loadDest_q <= '0;
            busReq_q   <= 1'b0;
            status_q   <= STATUS_START;
            for (int i = 0; i < NREG; i++) regFile_q[i] <= '0;
        end else begin
            aluOut_q   <= aluOut_d;
            addr_q     <= addr_d;
            loadDest_q <= loadDest_d;
            busReq_q   <= busReq_d;
            status_q   <= status_d;
            if (regWe) regFile_q[regWaddr] <= regWdata;
        end
    end

    assign alu_out         = aluOut_q;
    assign addr_out        = addr_q;
    assign bus_request_out = busReq_q;
    assign status_out      = status_q;

endmodule

// File: tb/tb_processor.sv
// tb_processor
// Directed bench for processor. Each stimulus step pushes the outputs it
// expects after its clock edge onto a scoreboard queue; an independent monitor
// pops and compares on the following falling edge. Register contents are made
// visible through OR Rx,Rx, which copies Rx to alu_out without changing it.

module tb_processor;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [11:0] vector_in;
    logic [7:0]  data_in;
    logic        bus_grant_in;
    logic [7:0]  alu_out;
    logic [3:0]  addr_out;
    logic        bus_request_out;
    logic        status_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] alu;
        logic [3:0] addr;
        logic       req;
        logic       stat;
    } expT;

    expT  sbQ[$];
    event sampleEv;

    always #5 clk = ~clk;

    processor #(
        .CONTROL_WIDTH (4),
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (8)
    ) dut (
        .clk             (clk),
        .reset_in        (reset_in),
        .vector_in       (vector_in),
        .data_in         (data_in),
        .bus_grant_in    (bus_grant_in),
        .alu_out         (alu_out),
        .addr_out        (addr_out),
        .bus_request_out (bus_request_out),
        .status_out      (status_out)
    );

    task automatic pushExp(input string name, input logic [7:0] eAlu, input logic [3:0] eAddr,
                           input logic eReq, input logic eStat);
        expT e;
        e.name = name;
        e.alu  = eAlu;
        e.addr = eAddr;
        e.req  = eReq;
        e.stat = eStat;
        sbQ.push_back(e);
    endtask

    // Drive one instruction for one clock edge and record the expected outputs.
    task automatic applyStimulus(input string name, input logic [11:0] vec, input logic gnt,
                                 input logic [7:0] din, input logic [7:0] eAlu,
                                 input logic [3:0] eAddr, input logic eReq, input logic eStat);
        @(negedge clk);
        vector_in    = vec;
        bus_grant_in = gnt;
        data_in      = din;
        @(posedge clk);
        #1;
        pushExp(name, eAlu, eAddr, eReq, eStat);
    endtask

    // Complete LOAD into R[b] from address addr, grant given on two edges.
    task automatic loadReg(input string name, input logic [3:0] b, input logic [3:0] addr,
                           input logic [7:0] value, input logic [7:0] prevAlu);
        applyStimulus({name, "_issue"}, {4'b0111, addr, b}, 1'b0, 8'h00, prevAlu, addr, 1'b1, 1'b1);
        applyStimulus({name, "_grant"}, 12'h000, 1'b1, value, prevAlu, addr, 1'b1, 1'b1);
        applyStimulus({name, "_cap"},   12'h000, 1'b1, value, value,   addr, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input expT e);
        checks++;
        if (alu_out !== e.alu || addr_out !== e.addr ||
            bus_request_out !== e.req || status_out !== e.stat) begin
            errors++;
            $display("[TB] FAIL %s: got alu=%h addr=%h req=%b status=%b, expected alu=%h addr=%h req=%b status=%b",
                     e.name, alu_out, addr_out, bus_request_out, status_out,
                     e.alu, e.addr, e.req, e.stat);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk or sampleEv);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] mulExp;
`ifdef PROCESSOR_MUL_EN
        mulExp = 8'h10;
`else
        mulExp = 8'h11;
`endif
        reset_in     = 1'b1;
        vector_in    = '0;
        data_in      = '0;
        bus_grant_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pushExp("reset", 8'h00, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        reset_in = 1'b0;

        applyStimulus("add_zero",    12'b0001_0000_0101, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        applyStimulus("load15_iss",  12'b0111_1000_1111, 1'b0, 8'h00, 8'h00, 4'h8, 1'b1, 1'b1);
        applyStimulus("load15_wait", 12'b0000_0000_0000, 1'b1, 8'h55, 8'h00, 4'h8, 1'b1, 1'b1);
        applyStimulus("load15_cap",  12'b0000_0000_0000, 1'b1, 8'h55, 8'h55, 4'h8, 1'b0, 1'b1);
        applyStimulus("peek_r15",    12'b0100_1111_1111, 1'b0, 8'h00, 8'h55, 4'h8, 1'b0, 1'b1);

        loadReg("pre_r1", 4'd1, 4'd0, 8'h55, 8'h55);
        loadReg("pre_r6", 4'd6, 4'd3, 8'hAA, 8'h55);
        applyStimulus("mov",         12'b1010_0001_0110, 1'b0, 8'h00, 8'hAA, 4'h3, 1'b0, 1'b1);
        applyStimulus("add_wrap",    12'b0001_0001_0110, 1'b0, 8'h00, 8'h54, 4'h3, 1'b0, 1'b1);

        applyStimulus("drop_iss",    12'b0111_0010_0111, 1'b0, 8'h00, 8'h54, 4'h2, 1'b1, 1'b1);
        applyStimulus("drop_grant",  12'b1010_0001_0000, 1'b1, 8'h33, 8'h54, 4'h2, 1'b1, 1'b1);
        applyStimulus("drop_revoke", 12'b1010_0001_0000, 1'b0, 8'h33, 8'h54, 4'h2, 1'b1, 1'b1);
        applyStimulus("drop_hold",   12'b1010_0001_0000, 1'b0, 8'h33, 8'h54, 4'h2, 1'b1, 1'b1);
        applyStimulus("drop_regrnt", 12'b1010_0001_0000, 1'b1, 8'h77, 8'h54, 4'h2, 1'b1, 1'b1);
        applyStimulus("drop_cap",    12'b1010_0001_0000, 1'b1, 8'h77, 8'h77, 4'h2, 1'b0, 1'b1);
        applyStimulus("peek_r7",     12'b0100_0111_0111, 1'b0, 8'h00, 8'h77, 4'h2, 1'b0, 1'b1);
        applyStimulus("peek_r1",     12'b0100_0001_0001, 1'b0, 8'h00, 8'h54, 4'h2, 1'b0, 1'b1);

        loadReg("pre_r13", 4'd13, 4'd4, 8'h40, 8'h54);
        loadReg("pre_r11", 4'd11, 4'd5, 8'h15, 8'h40);
        applyStimulus("halt",        12'b1111_0000_0000, 1'b0, 8'h00, 8'h15, 4'h5, 1'b0, 1'b0);
        applyStimulus("halt_nop",    12'b0000_0000_0000, 1'b0, 8'h00, 8'h15, 4'h5, 1'b0, 1'b0);
        applyStimulus("wake_sub",    12'b0010_1101_1011, 1'b0, 8'h00, 8'h2B, 4'h5, 1'b0, 1'b1);
        applyStimulus("peek_r13",    12'b0100_1101_1101, 1'b0, 8'h00, 8'h2B, 4'h5, 1'b0, 1'b1);
        applyStimulus("undef_op",    12'b1100_0001_0001, 1'b0, 8'h00, 8'h2B, 4'h5, 1'b0, 1'b1);
        applyStimulus("peek_r1b",    12'b0100_0001_0001, 1'b0, 8'h00, 8'h54, 4'h5, 1'b0, 1'b1);

        loadReg("pre_r2", 4'd2, 4'd6, 8'h10, 8'h54);
        loadReg("pre_r3", 4'd3, 4'd7, 8'h11, 8'h10);
        applyStimulus("mul",         12'b1011_0010_0011, 1'b0, 8'h00, mulExp, 4'h7, 1'b0, 1'b1);
        applyStimulus("peek_r2",     12'b0100_0010_0010, 1'b0, 8'h00, 8'h10, 4'h7, 1'b0, 1'b1);
        applyStimulus("xor",         12'b0101_0010_0011, 1'b0, 8'h00, 8'h01, 4'h7, 1'b0, 1'b1);
        applyStimulus("not",         12'b0110_0100_0011, 1'b0, 8'h00, 8'hEE, 4'h7, 1'b0, 1'b1);
        applyStimulus("shl",         12'b1000_0100_0000, 1'b0, 8'h00, 8'hDC, 4'h7, 1'b0, 1'b1);
        applyStimulus("shr",         12'b1001_0100_0000, 1'b0, 8'h00, 8'h6E, 4'h7, 1'b0, 1'b1);
        applyStimulus("and",         12'b0011_1101_0011, 1'b0, 8'h00, 8'h01, 4'h7, 1'b0, 1'b1);
        applyStimulus("sub_wrap",    12'b0010_1101_0011, 1'b0, 8'h00, 8'hF0, 4'h7, 1'b0, 1'b1);

        applyStimulus("rst_load",    12'b0111_1001_0101, 1'b0, 8'h00, 8'hF0, 4'h9, 1'b1, 1'b1);
        applyStimulus("rst_wait",    12'b0000_0000_0000, 1'b0, 8'h00, 8'hF0, 4'h9, 1'b1, 1'b1);
        // Pulse reset entirely between clock edges so only an asynchronous
        // reset can clear the pending request.
        @(negedge clk);
        #1;
        vector_in    = '0;
        bus_grant_in = 1'b0;
        reset_in     = 1'b1;
        #1;
        pushExp("async_reset", 8'h00, 4'h0, 1'b0, 1'b1);
        ->sampleEv;
        #1;
        reset_in = 1'b0;
        applyStimulus("post_rst_r5",  12'b0100_0101_0101, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        applyStimulus("post_rst_r15", 12'b0100_1111_1111, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);

        for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clk);
        #1;
        if (sbQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left unchecked, required 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
